// File: rtl/traffic_phase_scheduler.sv
// Density-driven four-way phase sequencer feeding the lane demux (SEL/GO).
// Optional emergency preemption is compiled in with `define EMERGENCY_PREEMPT_EN.
module traffic_phase_scheduler #(
    parameter int DW       = 3,
    parameter int TW       = 8,
    parameter int T_BASE   = 10,
    parameter int T_STEP   = 5,
    parameter int T_YEL    = 3,
    parameter int T_ALLRED = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          TICK,
    input  logic [DW-1:0] DENS0,
    input  logic [DW-1:0] DENS1,
    input  logic [DW-1:0] DENS2,
    input  logic [DW-1:0] DENS3,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic          EMG,
    input  logic [1:0]    EMG_LANE,
`endif
    output logic [1:0]    SEL,
    output logic          GO,
    output logic          YEL,
    output logic [TW-1:0] REMAIN,
    output logic [1:0]    PHASE
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10,
        ALLRED = 2'b11
    } phase_t;

    // Full-width green sum so the saturation compare never sees a wrapped value.
    localparam int SW = TW + DW + $clog2(T_STEP + 1) + 1;
    localparam logic [SW-1:0] TMAX_W = {{(SW-TW){1'b0}}, {TW{1'b1}}};

    phase_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    last_q, last_d;
    logic [TW-1:0] remain_q, remain_d;

    logic [DW-1:0] dens [4];
    logic [DW-1:0] dens_sel;
    logic          hit;
    logic [1:0]    hit_lane;
    logic [SW-1:0] sum_full;
    logic [TW-1:0] green_load;

    assign dens[0]  = DENS0;
    assign dens[1]  = DENS1;
    assign dens[2]  = DENS2;
    assign dens[3]  = DENS3;
    assign dens_sel = dens[sel_q];

    // Round-robin scan starting just after the last granted lane.
    always_comb begin
        hit      = 1'b0;
        hit_lane = last_q;
        for (int i = 1; i <= 4; i++) begin
            if (!hit && dens[last_q + 2'(i)] != '0) begin
                hit      = 1'b1;
                hit_lane = last_q + 2'(i);
            end
        end
    end

    always_comb begin
        sum_full   = SW'(T_BASE) + SW'(dens[hit_lane]) * SW'(T_STEP);
        green_load = (sum_full > TMAX_W) ? {TW{1'b1}} : sum_full[TW-1:0];
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        remain_d = remain_q;
        case (state_q)
            IDLE: begin
`ifdef EMERGENCY_PREEMPT_EN
                if (EMG) begin
                    state_d  = GREEN;
                    sel_d    = EMG_LANE;
                    last_d   = EMG_LANE;
                    remain_d = TW'(T_BASE);
                end else
`endif
                if (hit) begin
                    state_d  = GREEN;
                    sel_d    = hit_lane;
                    last_d   = hit_lane;
                    remain_d = green_load;
                end
            end
            GREEN: begin
`ifdef EMERGENCY_PREEMPT_EN
                if (EMG && EMG_LANE == sel_q) begin
                    state_d = GREEN;
                end else if (EMG) begin
                    state_d  = YELLOW;
                    remain_d = TW'(T_YEL);
                end else
`endif
                if (TICK) begin
                    // Gap-out ends green early whatever time is left.
                    if (dens_sel == '0 || remain_q == TW'(1)) begin
                        state_d  = YELLOW;
                        remain_d = TW'(T_YEL);
                    end else begin
                        remain_d = remain_q - TW'(1);
                    end
                end
            end
            YELLOW: begin
                if (TICK) begin
                    if (remain_q == TW'(1)) begin
                        state_d  = ALLRED;
                        remain_d = TW'(T_ALLRED);
                    end else begin
                        remain_d = remain_q - TW'(1);
                    end
                end
            end
            ALLRED: begin
                if (TICK) begin
                    if (remain_q == TW'(1)) begin
                        state_d  = IDLE;
                        remain_d = '0;
                    end else begin
                        remain_d = remain_q - TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_q resets to 3 so the first scan begins at lane 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            sel_q    <= 2'd0;
            last_q   <= 2'd3;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            remain_q <= remain_d;
        end
    end

    assign SEL    = sel_q;
    assign GO     = (state_q == GREEN);
    assign YEL    = (state_q == YELLOW);
    assign REMAIN = remain_q;
    assign PHASE  = state_q;

endmodule
